cla_3bit: RTL and testbench



---
 rtl/cla_pkg.sv | 35 +++
 rtl/cla_3bit_if.sv | 25 ++
 rtl/cla_gp_cell.sv | 14 +
 rtl/cla_3bit.sv | 88 ++++++++
 tb/tb_cla_3bit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder family: slice width and the
// flat sum-of-products carry term, reused by any higher-level lookahead unit.
package cla_pkg;

  localparam int CLA_WIDTH     = 3;
  localparam int CLA_MAX_WIDTH = 8;

  typedef logic [CLA_WIDTH-1:0] cla_word_t;

  // Carry into bit idx+1: g[idx] | p[idx]g[idx-1] | ... | p[idx]..p[0]cin.
  // Every product term is built from g/p/cin directly, so no carry feeds another.
  function automatic logic cla_carry(input logic [CLA_MAX_WIDTH-1:0] g,
                                     input logic [CLA_MAX_WIDTH-1:0] p,
                                     input logic                     cin,
                                     input int                       idx);
    logic acc;
    logic term;
    term = cin;
    for (int k = 0; k < CLA_MAX_WIDTH; k++) begin
      if (k <= idx) term &= p[k];
    end
    acc = term;
    for (int j = 0; j < CLA_MAX_WIDTH; j++) begin
      if (j <= idx) begin
        term = g[j];
        for (int k = j + 1; k < CLA_MAX_WIDTH; k++) begin
          if (k <= idx) term &= p[k];
        end
        acc |= term;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/cla_3bit_if.sv
// Operand/result bundle for one lookahead slice. Group generate/propagate
// signals exist only when CLA_GROUP_GP_EN is defined.
interface cla_3bit_if
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
);
  logic             in_valid;
  logic             c;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] s;
  logic             c12;
  logic             out_valid;
`ifdef CLA_GROUP_GP_EN
  logic             gp_p;
  logic             gp_g;

  modport master (output in_valid, c, x, y, input s, c12, out_valid, gp_p, gp_g);
  modport slave  (input in_valid, c, x, y, output s, c12, out_valid, gp_p, gp_g);
`else
  modport master (output in_valid, c, x, y, input s, c12, out_valid);
  modport slave  (input in_valid, c, x, y, output s, c12, out_valid);
`endif
endinterface

// File: rtl/cla_gp_cell.sv
// Single-bit generate/propagate/sum cell; the carry into the bit comes from
// the lookahead network in the parent.
module cla_gp_cell (
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_g,
  output logic o_p,
  output logic o_s
);
  assign o_g = i_x & i_y;
  assign o_p = i_x ^ i_y;
  assign o_s = o_p ^ i_c;
endmodule

// File: rtl/cla_3bit.sv
// Registered carry-lookahead adder slice, s/c12 = x + y + c with one cycle of
// latency. Defining CLA_GROUP_GP_EN adds registered group propagate/generate.
module cla_3bit
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input logic        clk,
  input logic        rst,
  cla_3bit_if.slave  bus
);
  logic [WIDTH-1:0]         w_g;
  logic [WIDTH-1:0]         w_p;
  logic [WIDTH-1:0]         w_sum;
  logic [WIDTH:0]           w_c;
  logic [CLA_MAX_WIDTH-1:0] w_g_ext;
  logic [CLA_MAX_WIDTH-1:0] w_p_ext;

  logic [WIDTH-1:0] r_s;
  logic             r_c12;
  logic             r_valid;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_g_ext            = '0;
    w_p_ext            = '0;
    w_g_ext[WIDTH-1:0] = w_g;
    w_p_ext[WIDTH-1:0] = w_p;
  end

  assign w_c[0] = bus.c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cla_gp_cell u_cell (
      .i_x (bus.x[i]),
      .i_y (bus.y[i]),
      .i_c (w_c[i]),
      .o_g (w_g[i]),
      .o_p (w_p[i]),
      .o_s (w_sum[i])
    );
    assign w_c[i+1] = cla_carry(w_g_ext, w_p_ext, bus.c, i);
  end

  // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s     <= '0;
      r_c12   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s   <= w_sum;
        r_c12 <= w_c[WIDTH];
      end
    end
  end

  assign bus.s         = r_s;
  assign bus.c12       = r_c12;
  assign bus.out_valid = r_valid;

`ifdef CLA_GROUP_GP_EN
  // Group terms let a parent build a second lookahead level across slices.
  logic w_gp_p;
  logic w_gp_g;
  logic r_gp_p;
  logic r_gp_g;

  assign w_gp_p = &w_p;
  assign w_gp_g = cla_carry(w_g_ext, w_p_ext, 1'b0, WIDTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gp_p <= 1'b0;
      r_gp_g <= 1'b0;
    end else if (bus.in_valid) begin
      r_gp_p <= w_gp_p;
      r_gp_g <= w_gp_g;
    end
  end

  assign bus.gp_p = r_gp_p;
  assign bus.gp_g = r_gp_g;
`endif

endmodule

// File: tb/tb_cla_3bit.sv
// Self-checking bench for cla_3bit: directed vector table, exhaustive
// scoreboarded sweep, and a four-slice 12-bit cascade.
module tb_cla_3bit;
  import cla_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_3bit_if #(.WIDTH(CLA_WIDTH)) bus ();

  cla_3bit #(.WIDTH(CLA_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Four-slice cascade, each slice's registered c12 feeding the next c.
  logic        cas_valid;
  logic        cas_c0;
  logic [11:0] cas_x;
  logic [11:0] cas_y;
  logic [11:0] cas_s;
  logic [3:0]  cas_c12;
  logic [3:0]  cas_ov;

  for (genvar k = 0; k < 4; k++) begin : g_slice
    cla_3bit_if #(.WIDTH(3)) sif ();
    assign sif.in_valid = cas_valid;
    assign sif.x        = cas_x[3*k +: 3];
    assign sif.y        = cas_y[3*k +: 3];
    if (k == 0) begin : g_first
      assign sif.c = cas_c0;
    end else begin : g_rest
      assign sif.c = cas_c12[k-1];
    end
    assign cas_s[3*k +: 3] = sif.s;
    assign cas_c12[k]      = sif.c12;
    assign cas_ov[k]       = sif.out_valid;
    cla_3bit #(.WIDTH(3)) u_slice (
      .clk (clk),
      .rst (rst),
      .bus (sif)
    );
  end

  typedef struct {
    logic       rst;
    logic       iv;
    logic [2:0] x;
    logic [2:0] y;
    logic       c;
    logic [2:0] s;
    logic       c12;
    logic       v;
    logic       gp_p;
    logic       gp_g;
  } vec_t;

  typedef struct {
    logic [2:0] s;
    logic       c12;
    logic       gp_p;
    logic       gp_g;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [2:0] x,
                       input logic [2:0] y, input logic c);
    rst          = r;
    bus.in_valid = iv;
    bus.x        = x;
    bus.y        = y;
    bus.c        = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.c        = 1'b0;
    cas_valid    = 1'b0;
    cas_c0       = 1'b0;
    cas_x        = '0;
    cas_y        = '0;

    //            rst iv  x     y     c     s     c12 v   gp_p gp_g
    vecs.push_back('{1, 1, 3'd7, 3'd7, 1, 3'd0, 0, 0, 0, 0}); // reset overrides in_valid
    vecs.push_back('{1, 1, 3'd7, 3'd7, 1, 3'd0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 3'd3, 3'd2, 0, 3'd5, 0, 1, 0, 0}); // basic add
    vecs.push_back('{0, 1, 3'd7, 3'd0, 1, 3'd0, 1, 1, 1, 0}); // full propagate
    vecs.push_back('{0, 1, 3'd7, 3'd7, 1, 3'd7, 1, 1, 0, 1}); // max operands
    vecs.push_back('{0, 1, 3'd5, 3'd1, 0, 3'd6, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 3'd7, 3'd7, 1, 3'd6, 0, 0, 0, 0}); // hold
    vecs.push_back('{0, 1, 3'd0, 3'd0, 0, 3'd0, 0, 1, 0, 0}); // all zero
    vecs.push_back('{0, 1, 3'd7, 3'd7, 1, 3'd7, 1, 1, 0, 1});
    vecs.push_back('{1, 1, 3'd3, 3'd3, 0, 3'd0, 0, 0, 0, 0}); // mid-stream reset
    vecs.push_back('{0, 1, 3'd2, 3'd2, 1, 3'd5, 0, 1, 0, 0}); // first after reset
    vecs.push_back('{0, 1, 3'd6, 3'd3, 0, 3'd1, 1, 1, 0, 1});
    vecs.push_back('{0, 1, 3'd4, 3'd3, 0, 3'd7, 0, 1, 1, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].x, vecs[i].y, vecs[i].c);
      check($sformatf("vec%0d.s", i),         32'(bus.s),         32'(vecs[i].s));
      check($sformatf("vec%0d.c12", i),       32'(bus.c12),       32'(vecs[i].c12));
      check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].v));
`ifdef CLA_GROUP_GP_EN
      check($sformatf("vec%0d.gp_p", i), 32'(bus.gp_p), 32'(vecs[i].gp_p));
      check($sformatf("vec%0d.gp_g", i), 32'(bus.gp_g), 32'(vecs[i].gp_g));
`endif
    end

    // Exhaustive sweep, back-to-back, expected results queued at drive time.
    for (int xi = 0; xi < 8; xi++) begin
      for (int yi = 0; yi < 8; yi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          logic [3:0] sum;
          logic [3:0] sum0;
          exp_t       e;
          exp_t       got;
          sum    = 4'(xi) + 4'(yi) + 4'(ci);
          sum0   = 4'(xi) + 4'(yi);
          e.s    = sum[2:0];
          e.c12  = sum[3];
          e.gp_p = ((3'(xi) ^ 3'(yi)) == 3'b111);
          e.gp_g = sum0[3];
          sb.push_back(e);
          drive(1'b0, 1'b1, 3'(xi), 3'(yi), 1'(ci));
          check($sformatf("exh.valid x%0d y%0d c%0d", xi, yi, ci), 32'(bus.out_valid), 32'd1);
          if (bus.out_valid && sb.size() > 0) begin
            got = sb.pop_front();
            check($sformatf("exh.sum x%0d y%0d c%0d", xi, yi, ci),
                  32'({bus.c12, bus.s}), 32'({got.c12, got.s}));
`ifdef CLA_GROUP_GP_EN
            check($sformatf("exh.gp x%0d y%0d c%0d", xi, yi, ci),
                  32'({bus.gp_p, bus.gp_g}), 32'({got.gp_p, got.gp_g}));
`endif
          end
        end
      end
    end
    check("exh.scoreboard_empty", 32'(sb.size()), 32'd0);

    // 12-bit cascade: carry crosses one slice per cycle, so allow it to settle.
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    cas_x     = 12'hFFF;
    cas_y     = 12'h001;
    cas_c0    = 1'b0;
    cas_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("cascade.s",         32'(cas_s),      32'h000);
    check("cascade.c12",       32'(cas_c12[3]), 32'd1);
    check("cascade.out_valid", 32'(cas_ov),     32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
